// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a requested number of words from a synchronous
// FIFO with one-cycle registered read latency and presents them as a
// valid/ready stream, tagging the final word with m_last. A 2-entry output
// buffer absorbs the read latency so the stream sustains one word per cycle
// under continuous m_ready, and holds data stable under backpressure.
module fifo_burst_reader #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t            state;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  issue_cnt;
    logic [LEN_W-1:0]  out_cnt;

    logic [1:0]        occ;
    logic              vld_p1;
    logic              last_p1;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] tail_data;
    logic              head_last;
    logic              tail_last;

    logic              pop;
    logic              issue_last;
    logic              out_last;
    logic [2:0]        fill;

    // Stream outputs come straight from the head buffer entry, so m_valid
    // never depends on m_ready.
    assign m_valid    = (occ != 2'd0);
    assign m_data     = head_data;
    assign m_last     = head_last;
    assign pop        = m_valid && m_ready;

    // Slots already committed: buffered words plus the read still in flight.
    assign fill       = {1'b0, occ} + {2'b00, vld_p1};
    assign issue_last = (issue_cnt + LEN_W'(1)) == len_r;
    assign out_last   = (out_cnt + LEN_W'(1)) == len_r;

    // A read is issued only if a buffer slot is guaranteed free when its
    // data returns, counting the slot freed by this cycle's pop.
    assign fifo_rd_en = (state == ST_RUN) && !fifo_empty && (issue_cnt < len_r)
                        && (fill <= (3'd1 + {2'b00, pop}));

    // Transfer control: state, length and counters, with registered status pulses.
    always_ff @(posedge clk) begin
        if (n_reset) begin
            state     <= ST_IDLE;
            len_r     <= '0;
            issue_cnt <= '0;
            out_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            err  <= start && (state != ST_IDLE);
            done <= 1'b0;
            if (fifo_rd_en) begin
                issue_cnt <= issue_cnt + LEN_W'(1);
            end
            if (pop) begin
                out_cnt <= out_cnt + LEN_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_r     <= len;
                        issue_cnt <= '0;
                        out_cnt   <= '0;
                        busy      <= 1'b1;
                        state     <= (len == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (fifo_rd_en && issue_last) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // done lines up with the DONE cycle right after the last handshake.
                    if (pop && out_last) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // An empty transfer has no handshake to trigger done early.
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    if (len_r == '0) begin
                        done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read-latency stage and 2-entry in-order output buffer.
    always_ff @(posedge clk) begin
        if (n_reset) begin
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
            occ       <= 2'd0;
            head_data <= '0;
            head_last <= 1'b0;
            tail_data <= '0;
            tail_last <= 1'b0;
        end else begin
            vld_p1  <= fifo_rd_en;
            last_p1 <= fifo_rd_en && issue_last;
            case ({vld_p1, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head_data <= fifo_data;
                        head_last <= last_p1;
                    end else begin
                        tail_data <= fifo_data;
                        tail_last <= last_p1;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head_data <= tail_data;
                    head_last <= tail_last;
                    occ       <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head_data <= fifo_data;
                        head_last <= last_p1;
                    end else begin
                        head_data <= tail_data;
                        head_last <= tail_last;
                        tail_data <= fifo_data;
                        tail_last <= last_p1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Testbench for fifo_burst_reader: behavioural FIFO model, scoreboard of
// hand-written expected words, and a negedge monitor that checks every
// handshake and stream stability independently of the stimulus.
module tb_fifo_burst_reader;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 16;

    logic              clk = 1'b0;
    logic              n_reset;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic              err;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_data = '0;
    logic              fifo_empty = 1'b1;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;

    always #5 clk = ~clk;

    fifo_burst_reader #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // FIFO model: registered data and empty flag, one-cycle read latency.
    logic [DATA_W-1:0] fifo_q[$];
    int fifo_err = 0;
    always @(posedge clk) begin
        if (fifo_rd_en === 1'b1) begin
            if (fifo_q.size() == 0) fifo_err++;
            else fifo_data <= fifo_q.pop_front();
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard and monitor state
    logic [DATA_W:0] exp_q[$];
    int hs_cyc_q[$];
    int hs_total = 0, rd_total = 0, valid_total = 0;
    int done_cnt = 0, done_cyc = 0, err_cnt = 0, err_cyc = 0, last_hs_cyc = 0;
    int empty_viol = 0, max_out = 0, out_rd = 0, out_hs = 0;
    logic stall_prev = 1'b0, rst_prev = 1'b1, stall_last = 1'b0;
    logic [DATA_W-1:0] stall_data = '0;

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [DATA_W:0] e;
        if (fifo_rd_en === 1'b1) begin
            rd_total++;
            if (fifo_empty) empty_viol++;
        end
        if (m_valid === 1'b1) valid_total++;
        if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (err === 1'b1) begin err_cnt++; err_cyc = cyc; end
        if (out_rd - out_hs > max_out) max_out = out_rd - out_hs;
        if (stall_prev && !rst_prev) begin
            chk("hold_valid", 32'(m_valid), 32'd1);
            chk("hold_data", 32'(m_data), 32'(stall_data));
            chk("hold_last", 32'(m_last), 32'(stall_last));
        end
        if ((m_valid === 1'b1) && (m_ready === 1'b1)) begin
            hs_total++;
            last_hs_cyc = cyc;
            hs_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_word: got data %0h last %0b expected no word", m_data, m_last);
            end else begin
                e = exp_q.pop_front();
                chk("word_data", 32'(m_data), 32'(e[DATA_W-1:0]));
                chk("word_last", 32'(m_last), 32'(e[DATA_W]));
            end
            out_hs++;
        end
        if (fifo_rd_en === 1'b1) out_rd++;
        stall_prev = (m_valid === 1'b1) && (m_ready === 1'b0);
        stall_data = m_data;
        stall_last = m_last;
        rst_prev   = n_reset;
        if (n_reset === 1'b1) begin out_rd = 0; out_hs = 0; end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_word(input logic [DATA_W-1:0] d, input logic l);
        exp_q.push_back({l, d});
    endtask

    task automatic wait_done(input int d0, input string name, input int maxc);
        int n = 0;
        while (done_cnt == d0 && n < maxc) begin step(); n++; end
        if (done_cnt == d0) begin
            total_cnt++;
            $display("FAIL %s: got no done within %0d cycles expected a done pulse", name, maxc);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1);
    end

    initial begin
        int c0, d0, r0, h0, v0, e0, k;
        logic [3:0] pat;
        logic [3:0] zb_busy, zb_done;
        n_reset = 1'b1; start = 1'b0; len = '0; m_ready = 1'b1;
        repeat (3) step();
        // Reset state
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        step(); n_reset = 1'b0; step();

        // Basic transfer
        fifo_q.push_back(8'h11); fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h33); fifo_q.push_back(8'h44);
        step(); step();
        exp_word(8'h11, 1'b0); exp_word(8'h22, 1'b0); exp_word(8'h33, 1'b0); exp_word(8'h44, 1'b1);
        d0 = done_cnt; r0 = rd_total; hs_cyc_q.delete();
        start = 1'b1; len = 16'd4; c0 = cyc;
        step(); start = 1'b0;
        wait_done(d0, "basic_done", 30);
        chk("basic_hs_cnt", 32'(hs_cyc_q.size()), 32'd4);
        if (hs_cyc_q.size() == 4)
            for (int i = 0; i < 4; i++) chk("basic_hs_cycle", 32'(hs_cyc_q[i] - c0), 32'(3 + i));
        chk("basic_done_cyc", 32'(done_cyc - c0), 32'd7);
        chk("basic_rd_cnt", 32'(rd_total - r0), 32'd4);
        chk("basic_sb_empty", 32'(exp_q.size()), 32'd0);
        step(); step();

        // Backpressure: m_ready 1,0,0,1 repeating
        for (int i = 0; i < 6; i++) fifo_q.push_back(8'hA1 + 8'(i));
        step(); step();
        for (int i = 0; i < 6; i++) exp_word(8'hA1 + 8'(i), (i == 5));
        d0 = done_cnt; r0 = rd_total; h0 = hs_total; max_out = 0; pat = 4'b1001;
        start = 1'b1; len = 16'd6;
        step(); start = 1'b0;
        k = 0;
        while (done_cnt == d0 && k < 80) begin
            m_ready = pat[k % 4];
            step();
            k++;
        end
        m_ready = 1'b1;
        if (done_cnt == d0) begin
            total_cnt++;
            $display("FAIL bp_done: got no done within 80 cycles expected a done pulse");
        end
        chk("bp_hs_cnt", 32'(hs_total - h0), 32'd6);
        chk("bp_rd_cnt", 32'(rd_total - r0), 32'd6);
        chk("bp_done_after_last", 32'(done_cyc - last_hs_cyc), 32'd1);
        chk("bp_reads_ahead_le2", 32'(max_out <= 2), 32'd1);
        chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);
        step(); step();

        // Empty stall: one word now, two more later
        fifo_q.push_back(8'hB1);
        step(); step();
        exp_word(8'hB1, 1'b0); exp_word(8'hB2, 1'b0); exp_word(8'hB3, 1'b1);
        d0 = done_cnt; r0 = rd_total;
        start = 1'b1; len = 16'd3;
        step(); start = 1'b0;
        repeat (4) step();
        fifo_q.push_back(8'hB2); fifo_q.push_back(8'hB3);
        wait_done(d0, "stall_done", 40);
        chk("stall_rd_cnt", 32'(rd_total - r0), 32'd3);
        chk("stall_no_rd_when_empty", 32'(empty_viol), 32'd0);
        chk("stall_fifo_err", 32'(fifo_err), 32'd0);
        chk("stall_sb_empty", 32'(exp_q.size()), 32'd0);
        step(); step();

        // Zero length
        zb_busy = 4'b0010; zb_done = 4'b0100;
        d0 = done_cnt; r0 = rd_total; v0 = valid_total;
        start = 1'b1; len = 16'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("zero_busy", 32'(busy), 32'(zb_busy[i]));
            chk("zero_done", 32'(done), 32'(zb_done[i]));
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("zero_rd_cnt", 32'(rd_total - r0), 32'd0);
        chk("zero_valid_cnt", 32'(valid_total - v0), 32'd0);
        chk("zero_done_cnt", 32'(done_cnt - d0), 32'd1);
        step();

        // Start while busy
        for (int i = 0; i < 6; i++) fifo_q.push_back(8'hE1 + 8'(i));
        step(); step();
        for (int i = 0; i < 4; i++) exp_word(8'hE1 + 8'(i), (i == 3));
        d0 = done_cnt; r0 = rd_total; e0 = err_cnt;
        start = 1'b1; len = 16'd4; c0 = cyc;
        step(); start = 1'b0;
        step(); start = 1'b1; len = 16'd9;
        step(); start = 1'b0;
        wait_done(d0, "busy_done", 30);
        chk("busy_err_cnt", 32'(err_cnt - e0), 32'd1);
        chk("busy_err_cyc", 32'(err_cyc - c0), 32'd3);
        chk("busy_done_cyc", 32'(done_cyc - c0), 32'd7);
        chk("busy_rd_cnt", 32'(rd_total - r0), 32'd4);
        chk("busy_fifo_left", 32'(fifo_q.size()), 32'd2);
        chk("busy_sb_empty", 32'(exp_q.size()), 32'd0);
        fifo_q.delete();
        step(); step(); step();

        // Reset mid-transfer
        for (int i = 0; i < 7; i++) fifo_q.push_back(8'hD1 + 8'(i));
        step(); step();
        for (int i = 0; i < 5; i++) exp_word(8'hD1 + 8'(i), (i == 4));
        h0 = hs_total;
        start = 1'b1; len = 16'd5;
        step(); start = 1'b0;
        repeat (4) step();
        n_reset = 1'b1; m_ready = 1'b0; exp_q.delete();
        d0 = done_cnt;
        step(); n_reset = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_m_valid", 32'(m_valid), 32'd0);
        chk("mrst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("mrst_hs_cnt", 32'(hs_total - h0), 32'd2);
        repeat (4) step();
        chk("mrst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("mrst_fifo_left", 32'(fifo_q.size()), 32'd3);
        exp_word(8'hD5, 1'b0); exp_word(8'hD6, 1'b1);
        r0 = rd_total; h0 = hs_total;
        start = 1'b1; len = 16'd2;
        step(); start = 1'b0;
        wait_done(d0, "mrst_restart_done", 30);
        chk("mrst_restart_hs", 32'(hs_total - h0), 32'd2);
        chk("mrst_restart_rd", 32'(rd_total - r0), 32'd2);
        chk("mrst_sb_empty", 32'(exp_q.size()), 32'd0);
        step(); step();

        chk("final_no_rd_when_empty", 32'(empty_viol), 32'd0);
        chk("final_fifo_err", 32'(fifo_err), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side master for the team's synchronous FIFO.
- On a start command it drains exactly `len` words from the FIFO and presents them downstream as a valid/ready stream. The final word is tagged with m_last.
- Handles the FIFO's one-cycle registered read latency and downstream backpressure with a 2-entry output buffer.
- Sits between the input FIFO and the LZ4 literal/token consumer. Sustains 1 word/cycle when the FIFO is non-empty and m_ready=1.

Parameters:
- DATA_W, 8, FIFO and stream data width.
- LEN_W, 16, width of the transfer length and internal counters.

Ports:
- clk  in  1  clock
- n_reset  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse: begin a transfer of `len` words
- len  in  LEN_W  words to transfer; sampled on accepted start
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse: transfer complete
- err  out  1  one-cycle pulse: start received while busy
- fifo_rd_en  out  1  read strobe to the FIFO
- fifo_data  in  DATA_W  FIFO data_out; valid the cycle after an accepted rd_en
- fifo_empty  in  1  FIFO empty flag (registered)
- m_valid  out  1  output word valid
- m_data  out  DATA_W  output word
- m_last  out  1  high with the final word of the transfer
- m_ready  in  1  downstream accept

Behaviour:
- Reset (n_reset=1 at a clk edge, synchronous, active-high):
  - state=IDLE; all counters 0; buffer emptied; in-flight read discarded.
  - busy=0, done=0, err=0, fifo_rd_en=0, m_valid=0, m_data=0, m_last=0.
  - Reset overrides every other input, including mid-transfer. No done is produced for an aborted transfer.
- State machine:
  - IDLE:
    - start=1 latches len into len_r and clears issue_cnt and out_cnt.
    - len=0: next state DONE, no reads issued.
    - len>0: next state RUN.
  - RUN: issue reads per the issue rule. When issue_cnt==len_r after an issue, go to DRAIN.
  - DRAIN: no further reads. When out_cnt==len_r (all words handshaken), go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- busy = 1 in RUN, DRAIN and DONE; 0 in IDLE.
- start while busy: ignored (len_r unchanged); err=1 the following cycle for one cycle.
- start with n_reset=1: ignored.
- Issue rule (combinational fifo_rd_en):
  - fifo_rd_en = (state==RUN) && !fifo_empty && (issue_cnt<len_r) && (occ + inflight - pop <= 1).
  - occ = buffer occupancy (0..2).
  - inflight = a read issued last cycle (0/1).
  - pop = m_valid && m_ready.
  - fifo_rd_en is never asserted while fifo_empty=1, so FIFO err is never triggered by this block.
- Data path:
  - rd_en high in cycle N: fifo_data captured at the end of cycle N+1; word appears on m_data with m_valid=1 in cycle N+2.
  - First-word latency: start at edge 0 → RUN in cycle 1 → rd_en in cycle 1 → m_valid in cycle 3.
  - Buffer is 2-entry, in-order; m_data/m_valid/m_last driven from the head entry.
  - The buffer never overflows: the issue rule reserves a slot for every in-flight read.
- Stream rules:
  - Once m_valid=1, m_data and m_last hold stable until handshake (AXI-style).
  - m_valid does not depend combinationally on m_ready.
  - A word is consumed only when m_valid && m_ready.
- m_last = 1 on the word whose handshake makes out_cnt==len_r.
- done asserts in the cycle after the last handshake.
- Counters: issue_cnt increments on each fifo_rd_en; out_cnt increments on each pop. Both are LEN_W bits. Max len = 2^LEN_W−1; no wrap.
- Simultaneous push and pop on the buffer in the same cycle: occupancy unchanged, order preserved.
- FIFO going empty mid-transfer: issue stalls; the buffer drains normally; issue resumes the cycle fifo_empty deasserts.

Test Plan:
- Basic transfer:
  - FIFO preloaded with 0x11,0x22,0x33,0x44; m_ready=1; start with len=4.
  - Required: m_data 0x11..0x44 in 4 consecutive cycles starting cycle 3; m_last only on 0x44; done one cycle later; exactly 4 rd_en pulses.
- Backpressure:
  - len=6, FIFO holds 6 words; m_ready toggles 1,0,0,1,…
  - Required: no data loss or duplication; m_data stable while m_valid && !m_ready; at most 2 reads ahead of consumption; done after the 6th handshake.
- Empty stall:
  - len=3, FIFO holds 1 word; remaining 2 words written 5 cycles later.
  - Required: fifo_rd_en=0 while fifo_empty=1; 3 words delivered in order; m_last on the 3rd; no FIFO err.
- Zero length:
  - start with len=0.
  - Required: no rd_en; no m_valid; busy high for 1 cycle (DONE state); done pulse in cycle 2.
- Start while busy:
  - second start with len=9 during a len=4 transfer.
  - Required: err pulse the next cycle; exactly 4 words transferred; len_r unaffected.
- Reset mid-transfer:
  - assert n_reset=1 after 2 of 5 words are delivered.
  - Required: next cycle busy=0, m_valid=0, fifo_rd_en=0, no done; a new start with len=2 then delivers the next 2 FIFO words correctly.
